// File: rtl/serial_encoder.sv
// -----------------------------------------------------------------------------
// serial_encoder
//   Sequential multi-hot to binary encoder. Accepts a W-bit request vector and
//   emits the index of every set bit, lowest index first, one index per
//   accepted output beat. Valid/ready handshake on both sides. A new vector can
//   be taken during the last beat of the current one, so there is no bubble
//   between vectors.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   clr        in   1  synchronous abort: drop pending bits, return to IDLE
//   in_valid   in   1  request vector valid
//   in_ready   out  1  block can accept a vector this cycle (combinational)
//   in         in   W  request vector; bit i set => emit index i
//   out_valid  out  1  out holds a valid index
//   out_ready  in   1  consumer accepts out this cycle
//   out        out  N  binary index of lowest set pending bit
//   out_last   out  1  current index is the final one of this vector
// -----------------------------------------------------------------------------
module serial_encoder (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [(1 << 3) - 1:0]  in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2:0]             out,
   output logic                   out_last
);

   localparam int N = 3;
   localparam int W = 1 << N;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   pend_q, pend_d;

   logic [N-1:0]   low_idx;
   logic           single_bit;
   logic           beat_taken;
   logic           vec_taken;

   // Lowest set bit of pend; scanning downwards lets the last hit win.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      low_idx = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (pend_q[i]) low_idx = N'(i);
      end
   end

   // Exactly one bit set: clearing the lowest set bit leaves nothing.
   assign single_bit = (pend_q != '0) && ((pend_q & (pend_q - 1'b1)) == '0);

   // Outputs decode from registered state only.
   assign out_valid = (state_q == ST_EMIT);
   assign out       = out_valid ? low_idx : '0;
   assign out_last  = out_valid && single_bit;

   // Sole combinational path through the block. Gated by rst_n so nothing is
   // offered as accepted while the block is held in reset.
   assign in_ready = rst_n && !clr &&
                     ((state_q == ST_IDLE) || (out_last && out_ready));

   assign beat_taken = out_valid && out_ready && !clr;
   assign vec_taken  = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      if (clr) begin
         state_d = ST_IDLE;
         pend_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // A zero vector is consumed without emitting anything.
               if (vec_taken && (in != '0)) begin
                  pend_d  = in;
                  state_d = ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (beat_taken) begin
                  pend_d = pend_q & (pend_q - 1'b1);
                  if (out_last) begin
                     state_d = ST_IDLE;
                     if (vec_taken && (in != '0)) begin
                        pend_d  = in;
                        state_d = ST_EMIT;
                     end
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               pend_d  = '0;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its next value from the same pre-edge snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_serial_encoder.sv
// -----------------------------------------------------------------------------
// tb_serial_encoder
//   Self-checking bench for serial_encoder. The reference model is a queue of
//   indices still to be emitted: an accepted vector pushes its set-bit indices
//   in ascending order, a taken beat pops the head, clr empties it.
// -----------------------------------------------------------------------------
module tb_serial_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_vec;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic       out_last;

   int tests_run    = 0;
   int tests_failed = 0;

   int exp_q[$];

   always #5 clk = ~clk;

   serial_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out_idx),
      .out_last  (out_last)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive at the falling edge, compare just after, then
   // advance the model across the rising edge.
   task automatic step(input logic v, input logic [7:0] vec, input logic ordy, input logic c);
      logic       e_valid, e_last, e_rdy;
      logic [2:0] e_out;
      @(negedge clk);
      in_valid  = v;
      in_vec    = vec;
      out_ready = ordy;
      clr       = c;
      #1;
      e_valid = (exp_q.size() > 0);
      e_out   = e_valid ? 3'(exp_q[0]) : 3'd0;
      e_last  = (exp_q.size() == 1);
      e_rdy   = !c && ((exp_q.size() == 0) || ((exp_q.size() == 1) && ordy));
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("out",       32'(out_idx),   32'(e_out));
      check("out_last",  32'(out_last),  32'(e_last));
      check("in_ready",  32'(in_ready),  32'(e_rdy));
      @(posedge clk);
      if (c) begin
         exp_q.delete();
      end else begin
         if (e_valid && ordy) exp_q.delete(0);
         if (v && e_rdy) begin
            for (int i = 0; i < 8; i++) begin
               if (vec[i]) exp_q.push_back(i);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_vec    = 8'h00;
      out_ready = 1'b1;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out",       32'(out_idx),   32'd0);
      check("rst_out_last",  32'(out_last),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 2,5,7 with last on 7, then back to IDLE
      step(1'b1, 8'b1010_0100, 1'b1, 1'b0);
      idle(4);

      // full vector
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      idle(9);

      // backpressure holds out=1
      step(1'b1, 8'h06, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
      idle(3);

      // zero vector, then back-to-back on the last beat
      step(1'b1, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h10, 1'b1, 1'b0);
      step(1'b1, 8'h81, 1'b1, 1'b0);
      idle(3);

      // clr after the first beat, with a vector offered alongside
      step(1'b1, 8'h0E, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h01, 1'b1, 1'b1);
      idle(2);

      // async reset mid-burst
      step(1'b1, 8'hF0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out",       32'(out_idx),   32'd0);
      check("arst_out_last",  32'(out_last),  32'd0);
      check("arst_in_ready",  32'(in_ready),  32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h02, 1'b1, 1'b0);
      idle(2);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic       v, ordy, c;
         logic [7:0] vec;
         v    = ($urandom_range(0, 1) == 1);
         ordy = ($urandom_range(0, 3) != 0);
         c    = ($urandom_range(0, 31) == 0);
         case ($urandom_range(0, 7))
            0:       vec = 8'h00;
            1:       vec = 8'hFF;
            2:       vec = 8'(1 << $urandom_range(0, 7));
            default: vec = 8'($urandom);
         endcase
         step(v, vec, ordy, c);
      end
      idle(10);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
